or1200_keccak_wbsrc: RTL and testbench
======================================

# or1200_keccak_wbsrc

Keccak result source for the writeback stage. Buffers 64-bit lanes from the Keccak permutation core in a small FIFO and serves them as 32-bit words on `muxin_keccak` of `or1200_wbmux` when the pipeline issues a Keccak read (rfwb_op = KECCAK). It stalls the pipeline when a read finds no data, and it honours `wb_freeze`.

## Interface
- `DW`, 32: writeback word width; equals `OR1200_OPERAND_WIDTH`.
- `LANE_W`, 64: Keccak lane width; fixed at 2*DW.
- `DEPTH`, 4: FIFO depth in lanes; must be a power of two and at least 2.
- `clk`  in  1  single clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `flush`  in  1  pipeline flush; synchronously empties the FIFO.
- `lane_valid`  in  1  core presents a lane.
- `lane_data`  in  LANE_W  lane; bits [31:0] are the low word.
- `lane_ready`  out  1  FIFO can accept a lane.
- `rd_req`  in  1  EX-stage Keccak read request (one word).
- `wb_freeze`  in  1  writeback freeze.
- `keccak_dataout`  out  DW  registered word to the wbmux keccak input.
- `keccak_stall`  out  1  read request cannot be served this cycle.
- `fifo_level`  out  clog2(DEPTH)+1  number of lanes held.

## Operation
- A push occurs when `lane_valid && lane_ready`. `lane_ready = (fifo_level != DEPTH)` and is decoded purely from registers, with no path from `rd_req`.
- A read is accepted when `rd_req && !wb_freeze && fifo_level != 0`.
- The `half` flag selects which word is served:
  - `half = 0`: serve `head[31:0]`, then set `half = 1`.
  - `half = 1`: serve `head[63:32]`, clear `half`, and pop the head lane.
- `keccak_stall = rd_req && (fifo_level == 0)`. This is combinational and does not depend on `wb_freeze`.
- Push and pop in the same cycle: the level is unchanged. Pointers wrap modulo DEPTH. While full, a push is refused even if a pop happens that cycle.
- A push while empty is readable on the next cycle. There is no bypass from `lane_data` to the read path.
- `flush` clears the pointers, `fifo_level` and `half`. It does not clear `keccak_dataout`. A push presented in the same cycle is dropped. `rst` has priority over `flush`.
- State values for `half`: READ_LO (0) and READ_HI (1). Transitions occur only on an accepted read, or on reset/flush (which return it to READ_LO).

## Timing
- Reset values: `keccak_dataout` = 0, `fifo_level` = 0, `half` = READ_LO, `lane_ready` = 1. `keccak_stall` = 0 when `rd_req` is low.
- Read latency is one cycle: a read accepted at edge N shows its word on `keccak_dataout` after edge N.
- While `wb_freeze` = 1, `keccak_dataout`, `half` and the read pointer hold their values. Pushes continue.
- When a stall clears (the lane arrives at edge N), the first read can be accepted in cycle N+1.
- Reset asserted mid-lane (`half = 1`) discards the remaining high word.

## Structure
- Shared package `or1200_keccak_pkg`:
  - `LANE_W`
  - the localparams `READ_LO` and `READ_HI`
  - the KECCAK `rfwb_op` encoding constant, shared with the wbmux decode
- One natural sub-module: `or1200_keccak_lanefifo`, a synchronous FIFO with parameters DEPTH and LANE_W and ports push, pop, level and head.
- The top level holds the `half` state, the accept logic and the output register.

## Test plan
- Reset, then push lane 64'h1111_2222_3333_4444 and issue two reads → `keccak_dataout` reads 32'h3333_4444 and then 32'h1111_2222; `fifo_level` goes 1→1→0.
- Read with the FIFO empty → `keccak_stall` = 1, `keccak_dataout` holds. Push a lane at cycle N → `keccak_stall` drops in N+1 and the low word appears in N+2.
- Push 4 lanes → `lane_ready` = 0 and a fifth `lane_valid` is dropped. Then read while pushing → the level stays 4 and no lane is lost. After wrap-around, lanes come out in order.
- Raise `wb_freeze` with `rd_req` held across the low/high boundary → output and `half` hold. Lower the freeze → reading resumes with the high word.
- Assert `flush` with `half = 1` and 3 lanes held → `fifo_level` = 0 and `half` = READ_LO; the next pushed lane serves its low word first.
- Pulse `rst` mid-operation while `flush` = 1 → all outputs take their reset values on the next edge.

Source files
------------

// File: rtl/or1200_keccak_pkg.sv
// or1200_keccak_pkg: shared Keccak writeback constants.
// Holds the lane width, the half-word read states and the KECCAK rfwb_op code used by the wbmux decode.
package or1200_keccak_pkg;
   localparam int LANE_W = 64;
   typedef enum logic {READ_LO = 1'b0, READ_HI = 1'b1} half_t;
   localparam logic [3:0] RFWBOP_KECCAK = 4'b1100;
endpackage

// File: rtl/or1200_keccak_wbsrc_if.sv
// or1200_keccak_wbsrc_if: lane-in / word-out bus of the Keccak writeback source.
// master drives flush, lane_valid, lane_data, rd_req and wb_freeze; slave returns lane_ready,
// keccak_dataout, keccak_stall and fifo_level.
interface or1200_keccak_wbsrc_if #(parameter int DW = 32, parameter int LANE_W = 64, parameter int DEPTH = 4);
   logic flush;
   logic lane_valid;
   logic [LANE_W-1:0] lane_data;
   logic lane_ready;
   logic rd_req;
   logic wb_freeze;
   logic [DW-1:0] keccak_dataout;
   logic keccak_stall;
   logic [$clog2(DEPTH):0] fifo_level;
   modport master(output flush, lane_valid, lane_data, rd_req, wb_freeze,
                  input lane_ready, keccak_dataout, keccak_stall, fifo_level);
   modport slave(input flush, lane_valid, lane_data, rd_req, wb_freeze,
                 output lane_ready, keccak_dataout, keccak_stall, fifo_level);
endinterface

// File: rtl/or1200_keccak_lanefifo.sv
// or1200_keccak_lanefifo: synchronous lane FIFO.
// Ports: clk, rst, flush (clear), push/din (write), pop (drop head), level (lanes held), head (oldest lane).
// The caller never pushes when full or pops when empty.
module or1200_keccak_lanefifo #(parameter int DEPTH = 4, parameter int LANE_W = 64) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic push,
   input  logic pop,
   input  logic [LANE_W-1:0] din,
   output logic [$clog2(DEPTH):0] level,
   output logic [LANE_W-1:0] head
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   logic [LANE_W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   assign head = mem[rd_ptr];
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= din;
   // Pointers wrap for free since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         level <= level + LW'(push) - LW'(pop);
      end
   end
endmodule

// File: rtl/or1200_keccak_wbsrc.sv
// or1200_keccak_wbsrc: serves buffered 64-bit Keccak lanes as two 32-bit writeback words, low word first.
// Ports: clk, rst (sync, active-high) and bus (slave side of or1200_keccak_wbsrc_if).
module or1200_keccak_wbsrc
   import or1200_keccak_pkg::half_t;
   import or1200_keccak_pkg::READ_LO;
   import or1200_keccak_pkg::READ_HI;
#(parameter int DW = 32, parameter int LANE_W = 2 * DW, parameter int DEPTH = 4) (
   input logic clk,
   input logic rst,
   or1200_keccak_wbsrc_if.slave bus
);
   localparam int LW = $clog2(DEPTH) + 1;
   half_t half;
   logic push, pop, rd_ok, has_data;
   logic [LANE_W-1:0] head;
   assign has_data = bus.fifo_level != '0;
   // Ready is decoded from the level register only, so there is no rd_req -> lane_ready path.
   assign bus.lane_ready = bus.fifo_level != LW'(DEPTH);
   assign push = bus.lane_valid && bus.lane_ready && !bus.flush;
   assign rd_ok = bus.rd_req && !bus.wb_freeze && has_data;
   assign pop = rd_ok && half == READ_HI;
   // Stall ignores freeze: an empty FIFO is reported even while writeback is frozen.
   assign bus.keccak_stall = bus.rd_req && !has_data;
   or1200_keccak_lanefifo #(.DEPTH(DEPTH), .LANE_W(LANE_W)) u_fifo (
      .clk(clk),
      .rst(rst),
      .flush(bus.flush),
      .push(push),
      .pop(pop),
      .din(bus.lane_data),
      .level(bus.fifo_level),
      .head(head)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         half <= READ_LO;
         bus.keccak_dataout <= '0;
      end else begin
         if (bus.flush) half <= READ_LO;
         else if (rd_ok) half <= half == READ_LO ? READ_HI : READ_LO;
         if (rd_ok) bus.keccak_dataout <= half == READ_HI ? head[LANE_W-1:DW] : head[DW-1:0];
      end
   end
endmodule

// File: tb/tb_or1200_keccak_wbsrc.sv
// tb_or1200_keccak_wbsrc: directed table, corner sequences and random traffic against a queue model.
module tb_or1200_keccak_wbsrc;
   typedef struct {
      bit r, f, v;
      logic [63:0] d;
      bit rd, fz;
      logic [31:0] dout;
      int lvl;
      bit rdy, stall;
   } vec_t;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   or1200_keccak_wbsrc_if #(.DW(32), .LANE_W(64), .DEPTH(4)) bus();
   or1200_keccak_wbsrc #(.DW(32), .LANE_W(64), .DEPTH(4)) dut(.clk(clk), .rst(rst), .bus(bus));
   int n_chk = 0, n_fail = 0;
   logic [63:0] mq[$];
   bit mhalf;
   logic [31:0] mdout;
   logic last_stall;
   vec_t tbl[15];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a lane queue plus a "high word next" flag, evaluated per clock edge.
   task automatic model(input bit r, f, v, input logic [63:0] d, input bit rd, fz);
      bit full, acc, pop;
      logic [63:0] lane;
      if (r) begin
         mq.delete();
         mhalf = 0;
         mdout = '0;
      end else begin
         full = mq.size() == 4;
         acc = rd && !fz && mq.size() != 0;
         pop = 0;
         if (acc) begin
            lane = mq[0];
            mdout = mhalf ? lane[63:32] : lane[31:0];
            pop = mhalf;
            mhalf = !mhalf;
         end
         if (f) begin
            mq.delete();
            mhalf = 0;
         end else begin
            if (pop) void'(mq.pop_front());
            if (v && !full) mq.push_back(d);
         end
      end
   endtask

   task automatic step(input bit r, f, v, input logic [63:0] d, input bit rd, fz);
      @(negedge clk);
      rst = r;
      bus.flush = f;
      bus.lane_valid = v;
      bus.lane_data = d;
      bus.rd_req = rd;
      bus.wb_freeze = fz;
      #1;
      last_stall = bus.keccak_stall;
      check("stall", 64'(bus.keccak_stall), 64'(rd && mq.size() == 0));
      @(posedge clk);
      model(r, f, v, d, rd, fz);
      #1;
      check("dout", 64'(bus.keccak_dataout), 64'(mdout));
      check("level", 64'(bus.fifo_level), 64'(mq.size()));
      check("ready", 64'(bus.lane_ready), 64'(mq.size() != 4));
      check("half", 64'(dut.half), 64'(mhalf));
   endtask

   initial begin
      rst = 1'b1;
      bus.flush = 1'b0;
      bus.lane_valid = 1'b0;
      bus.lane_data = '0;
      bus.rd_req = 1'b0;
      bus.wb_freeze = 1'b0;
      tbl[0]  = '{1, 0, 0, 64'h0, 0, 0, 32'h0, 0, 1, 0};
      tbl[1]  = '{0, 0, 1, 64'h1111_2222_3333_4444, 0, 0, 32'h0, 1, 1, 0};
      tbl[2]  = '{0, 0, 0, 64'h0, 1, 0, 32'h3333_4444, 1, 1, 0};
      tbl[3]  = '{0, 0, 0, 64'h0, 1, 0, 32'h1111_2222, 0, 1, 0};
      tbl[4]  = '{0, 0, 0, 64'h0, 1, 0, 32'h1111_2222, 0, 1, 1};
      tbl[5]  = '{0, 0, 1, 64'hAAAA_BBBB_CCCC_DDDD, 1, 0, 32'h1111_2222, 1, 1, 1};
      tbl[6]  = '{0, 0, 0, 64'h0, 1, 0, 32'hCCCC_DDDD, 1, 1, 0};
      tbl[7]  = '{0, 0, 0, 64'h0, 1, 1, 32'hCCCC_DDDD, 1, 1, 0};
      tbl[8]  = '{0, 0, 1, 64'h5555_6666_7777_8888, 1, 1, 32'hCCCC_DDDD, 2, 1, 0};
      tbl[9]  = '{0, 0, 0, 64'h0, 1, 0, 32'hAAAA_BBBB, 1, 1, 0};
      tbl[10] = '{0, 0, 0, 64'h0, 0, 0, 32'hAAAA_BBBB, 1, 1, 0};
      tbl[11] = '{0, 0, 0, 64'h0, 1, 0, 32'h7777_8888, 1, 1, 0};
      tbl[12] = '{0, 1, 1, 64'h9999_9999_9999_9999, 0, 0, 32'h7777_8888, 0, 1, 0};
      tbl[13] = '{0, 0, 1, 64'h0123_4567_89AB_CDEF, 0, 0, 32'h7777_8888, 1, 1, 0};
      tbl[14] = '{0, 0, 0, 64'h0, 1, 0, 32'h89AB_CDEF, 1, 1, 0};
      for (int i = 0; i < 15; i++) begin
         step(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].rd, tbl[i].fz);
         check($sformatf("tbl%0d_dout", i), 64'(bus.keccak_dataout), 64'(tbl[i].dout));
         check($sformatf("tbl%0d_level", i), 64'(bus.fifo_level), 64'(tbl[i].lvl));
         check($sformatf("tbl%0d_ready", i), 64'(bus.lane_ready), 64'(tbl[i].rdy));
         check($sformatf("tbl%0d_stall", i), 64'(last_stall), 64'(tbl[i].stall));
      end
      // Fill to four lanes; a fifth lane is refused, then drain in order.
      step(1, 0, 0, 64'h0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, {32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)}, 0, 0);
      check("full_level", 64'(bus.fifo_level), 64'd4);
      check("full_ready", 64'(bus.lane_ready), 64'd0);
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 0, 64'h0, 1, 0);
         check($sformatf("drain%0d", i), 64'(bus.keccak_dataout),
               64'(i[0] ? 32'hB000_0000 + 32'(i / 2) : 32'hA000_0000 + 32'(i / 2)));
      end
      check("drain_level", 64'(bus.fifo_level), 64'd0);
      // Flush with three lanes held and half set, then the next lane starts on its low word.
      for (int i = 0; i < 3; i++) step(0, 0, 1, {32'hD000_0000 + 32'(i), 32'hC000_0000 + 32'(i)}, 0, 0);
      step(0, 0, 0, 64'h0, 1, 0);
      check("pre_flush_half", 64'(dut.half), 64'd1);
      step(0, 1, 0, 64'h0, 0, 0);
      check("flush_level", 64'(bus.fifo_level), 64'd0);
      check("flush_dout", 64'(bus.keccak_dataout), 64'hC000_0000);
      step(0, 0, 1, 64'hEEEE_0001_FFFF_0002, 0, 0);
      step(0, 0, 0, 64'h0, 1, 0);
      check("post_flush_lo", 64'(bus.keccak_dataout), 64'hFFFF_0002);
      // Reset mid-lane with flush and a push present: everything returns to reset values.
      step(0, 0, 1, 64'h4444_0003_5555_0004, 0, 0);
      step(1, 1, 1, 64'h6666_6666_6666_6666, 1, 0);
      check("rst_dout", 64'(bus.keccak_dataout), 64'd0);
      check("rst_level", 64'(bus.fifo_level), 64'd0);
      check("rst_ready", 64'(bus.lane_ready), 64'd1);
      check("rst_half", 64'(dut.half), 64'd0);
      step(0, 0, 1, 64'h1234_5678_9ABC_DEF0, 0, 0);
      step(0, 0, 0, 64'h0, 1, 0);
      check("rst_then_lo", 64'(bus.keccak_dataout), 64'h9ABC_DEF0);
      // Random traffic against the model.
      for (int i = 0; i < 800; i++)
         step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
              {$urandom, $urandom}, $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
